// File: rtl/fifo_pkg.sv
// Shared constants and sizing helper for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 8;

  // Smallest n with 2**n >= value; used to size pointers and the occupancy count.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
);

  localparam int unsigned CntW = clog2(DEPTH) + 1;

  logic             write_en;
  logic [WIDTH-1:0] data_in;
  logic             read_en;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CntW-1:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write_en, data_in, read_en, flush, clear_err,
    input  out, out_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write_en, data_in, read_en, flush, clear_err,
    output out, out_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-before-write on the same address, so a full-FIFO read+write returns the old word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with wrap-bit pointers, status flags and sticky error flags.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic              clk,
  input logic              reset,
  param_sync_fifo_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AfLevel = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AeLevel = PW'(AE_LEVEL);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_count;
  logic [PW-1:0]    w_count_d;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [WIDTH-1:0] w_rd_data;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  always_comb begin
    w_rd_acc  = bus.read_en && !w_empty && !bus.flush;
    w_wr_acc  = bus.write_en && !bus.flush && (!w_full || w_rd_acc);
    w_ovf_set = bus.write_en && !w_wr_acc && !bus.flush;
    w_unf_set = bus.read_en && w_empty && !bus.flush;
    w_count_d = r_count;
    if (bus.flush) begin
      w_count_d = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_count_d = r_count + PW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_d = r_count - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_out_valid    <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count        <= w_count_d;
      r_almost_full  <= (w_count_d >= AfLevel);
      r_almost_empty <= (w_count_d <= AeLevel);
      r_out_valid    <= w_rd_acc;
      // A same-cycle set wins over clear_err.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (bus.clear_err) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (bus.clear_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_acc && reset),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (bus.data_in),
    .i_rd_en   (w_rd_acc && reset),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign bus.out          = w_rd_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (WIDTH=8, DEPTH=8, AF=6, AE=2).
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_d;
  logic [7:0] last_out;

  param_sync_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();

  param_sync_fifo #(
    .WIDTH    (8),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the edge.
  task automatic cyc(input logic we, input logic [7:0] d, input logic re, input logic fl,
                     input logic ce);
    bus.write_en  = we;
    bus.data_in   = d;
    bus.read_en   = re;
    bus.flush     = fl;
    bus.clear_err = ce;
    @(posedge clk);
    #1;
    bus.write_en  = 1'b0;
    bus.read_en   = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.write_en  = 1'b0;
    bus.data_in   = '0;
    bus.read_en   = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_empty", bus.empty, 1);
    check_eq("rst_full", bus.full, 0);
    check_eq("rst_ae", bus.almost_empty, 1);
    check_eq("rst_af", bus.almost_full, 0);
    check_eq("rst_out", bus.out, 0);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_ovf", bus.overflow, 0);
    check_eq("rst_unf", bus.underflow, 0);
    reset = 1'b1;

    // Fill with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      check_eq("fill_count", bus.count, i);
      check_eq("fill_af", bus.almost_full, (i >= 6));
      check_eq("fill_ae", bus.almost_empty, (i <= 2));
      check_eq("fill_full", bus.full, (i == 8));
      check_eq("fill_valid", bus.out_valid, 0);
    end
    cyc(1, 8'hFF, 0, 0, 0);
    check_eq("ovf_set", bus.overflow, 1);
    check_eq("ovf_count", bus.count, 8);
    check_eq("ovf_full", bus.full, 1);
    cyc(1, 8'hFE, 0, 0, 1);
    check_eq("ovf_set_beats_clear", bus.overflow, 1);
    cyc(0, 8'h00, 0, 0, 1);
    check_eq("ovf_clear", bus.overflow, 0);

    // Simultaneous read and write while full.
    cyc(1, 8'hAA, 1, 0, 0);
    check_eq("rw_full_out", bus.out, 8'h01);
    check_eq("rw_full_valid", bus.out_valid, 1);
    check_eq("rw_full_count", bus.count, 8);
    check_eq("rw_full_ovf", bus.overflow, 0);
    check_eq("rw_full_full", bus.full, 1);

    // Drain: 0x02..0x08 then 0xAA last.
    for (int i = 0; i < 8; i++) begin
      exp_d = (i < 7) ? 8'(i + 2) : 8'hAA;
      cyc(0, 8'h00, 1, 0, 0);
      check_eq("drain_out", bus.out, exp_d);
      check_eq("drain_valid", bus.out_valid, 1);
      check_eq("drain_count", bus.count, 7 - i);
    end
    check_eq("drain_empty", bus.empty, 1);
    cyc(0, 8'h00, 0, 0, 0);
    check_eq("hold_valid", bus.out_valid, 0);
    check_eq("hold_out", bus.out, 8'hAA);
    cyc(0, 8'h00, 1, 0, 0);
    check_eq("unf_set", bus.underflow, 1);
    check_eq("unf_valid", bus.out_valid, 0);
    check_eq("unf_out", bus.out, 8'hAA);
    cyc(0, 8'h00, 0, 0, 1);
    check_eq("unf_clear", bus.underflow, 0);

    // Wrap the pointers with a standing occupancy of 3.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'(8'h40 + i), 0, 0, 0);
      sb.push_back(8'(8'h40 + i));
      check_eq("pre_count", bus.count, i + 1);
      check_eq("pre_ae", bus.almost_empty, (i + 1 <= 2));
    end
    for (int i = 0; i < 20; i++) begin
      exp_d = sb.pop_front();
      sb.push_back(8'(8'h50 + i));
      cyc(1, 8'(8'h50 + i), 1, 0, 0);
      check_eq("wrap_out", bus.out, exp_d);
      check_eq("wrap_count", bus.count, 3);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'(8'h70 + i), 0, 0, 0);
      sb.push_back(8'(8'h70 + i));
      check_eq("up_af", bus.almost_full, (i + 4 >= 6));
    end
    for (int i = 0; i < 6; i++) begin
      exp_d = sb.pop_front();
      cyc(0, 8'h00, 1, 0, 0);
      last_out = exp_d;
      check_eq("down_out", bus.out, exp_d);
      check_eq("down_count", bus.count, 5 - i);
      check_eq("down_af", bus.almost_full, (5 - i >= 6));
      check_eq("down_ae", bus.almost_empty, (5 - i <= 2));
    end
    check_eq("down_empty", bus.empty, 1);

    // Flush with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'(8'h80 + i), 0, 0, 0);
    end
    check_eq("pf_count", bus.count, 5);
    cyc(1, 8'h99, 0, 1, 0);
    check_eq("fl_count", bus.count, 0);
    check_eq("fl_empty", bus.empty, 1);
    check_eq("fl_ae", bus.almost_empty, 1);
    check_eq("fl_ovf", bus.overflow, 0);
    check_eq("fl_valid", bus.out_valid, 0);
    check_eq("fl_out", bus.out, last_out);
    cyc(0, 8'h00, 1, 0, 0);
    check_eq("fl_unf", bus.underflow, 1);
    check_eq("fl_rd_valid", bus.out_valid, 0);
    cyc(0, 8'h00, 0, 0, 1);

    // Mid-stream reset with a read pending.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'(8'h90 + i), 0, 0, 0);
    end
    check_eq("mr_pre_count", bus.count, 3);
    reset = 1'b0;
    cyc(0, 8'h00, 1, 0, 0);
    reset = 1'b1;
    check_eq("mr_valid", bus.out_valid, 0);
    check_eq("mr_out", bus.out, 0);
    check_eq("mr_count", bus.count, 0);
    check_eq("mr_empty", bus.empty, 1);
    check_eq("mr_ae", bus.almost_empty, 1);
    check_eq("mr_unf", bus.underflow, 0);
    cyc(0, 8'h00, 0, 0, 0);
    check_eq("mr_valid_after", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries; power of two, 2..1024.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-007 The block SHALL have port write_en, input, 1, write request.
REQ-008 The block SHALL have port data_in, input, WIDTH, write data.
REQ-009 The block SHALL have port read_en, input, 1, read request.
REQ-010 The block SHALL have port flush, input, 1, synchronous discard of all stored entries.
REQ-011 The block SHALL have port clear_err, input, 1, clears the sticky error flags.
REQ-012 The block SHALL have port out, output, WIDTH, registered read data.
REQ-013 The block SHALL have port out_valid, output, 1, one-cycle pulse marking out as new data.
REQ-014 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1, occupancy status.
REQ-015 The block SHALL have port count, output, log2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-016 The block SHALL have ports overflow and underflow, each output, 1, sticky error flags.

Function
REQ-017 Pointers SHALL be log2(DEPTH)+1 bits wide; the MSB is a wrap bit and the lower bits address storage.
REQ-018 empty SHALL equal (wr_ptr == rd_ptr); full SHALL equal (MSBs differ and address bits equal); both are combinational from registered pointers.
REQ-019 A read SHALL be accepted iff read_en=1, empty=0 and flush=0.
REQ-020 A write SHALL be accepted iff write_en=1, flush=0 and (full=0 or a read is accepted in the same cycle).
REQ-021 An accepted read SHALL load the oldest entry into out and pulse out_valid in the following cycle (1-cycle latency); out SHALL hold its value otherwise.
REQ-022 Write-through when empty SHALL NOT occur: a word written into an empty FIFO becomes readable no earlier than the next cycle.
REQ-023 count SHALL increment on write-only, decrement on read-only, and hold on simultaneous accepted read and write or on neither.
REQ-024 almost_full SHALL be (count >= AF_LEVEL); almost_empty SHALL be (count <= AE_LEVEL); both are registered from the next-state count.
REQ-025 overflow SHALL set when write_en=1, the write is not accepted and flush=0; underflow SHALL set when read_en=1 and empty=1 and flush=0.
REQ-026 clear_err SHALL clear both flags; a same-cycle set SHALL take priority over clear.
REQ-027 flush SHALL zero both pointers and count and set empty/almost_empty next cycle; memory contents, out and the error flags SHALL be unaffected; out_valid SHALL be 0 that cycle.
REQ-028 Pointers SHALL wrap modulo 2*DEPTH with no special case at the DEPTH boundary.

Reset
REQ-029 With reset=0 at a clk edge, pointers, count, out, out_valid, overflow, underflow, full and almost_full SHALL become 0, and empty and almost_empty SHALL become 1.
REQ-030 Reset SHALL override flush, write and read in the same cycle; storage array contents SHALL NOT be reset.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight data; no out_valid pulse SHALL follow a read issued in the reset cycle.

Structure
REQ-032 A shared package fifo_pkg SHALL hold the default WIDTH/DEPTH constants and the ceil-log2 function used to size pointers and count.
REQ-033 Storage SHALL be a sub-module fifo_mem (simple dual-port array, one synchronous write port, one registered read port), instantiated once.

Verification
REQ-034 Reset, then write 0x01..0x08 -> full=1 and count=8 after the 8th write; a 9th write of 0xFF sets overflow=1, and count stays 8.
REQ-035 From full, perform 8 reads -> out=0x01..0x08 in order, each one cycle after the read; empty=1 after the last; a 9th read sets underflow=1.
REQ-036 From full, assert write_en=1 (0xAA) and read_en=1 together -> out=oldest entry, count stays 8, and 0xAA is read last; overflow does not set.
REQ-037 Perform 20 write/read pairs so the pointers wrap twice -> data order is preserved, and almost_full/almost_empty toggle exactly at count 6 and 2.
REQ-038 Write 5 words and assert flush together with write_en -> next cycle count=0 and empty=1, overflow stays unchanged, and the next read sets underflow.
REQ-039 Drop reset=0 for one cycle with read_en=1 at count=3 -> no out_valid pulse, out=0, count=0 and empty=1.
